// File: rtl/rgbled_pkg.sv
// Shared types and default timing for the rgbled_stream serial LED driver.
// Default constants assume a 10 MHz clock (100 ns per cycle).
package rgbled_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BIT_HI = 2'd1,
        BIT_LO = 2'd2,
        LATCH  = 2'd3
    } rgbled_state_t;

    localparam int unsigned CLK_HZ_DEF   = 10_000_000;
    localparam int unsigned T0H_CYC_DEF  = 4;     // 400 ns
    localparam int unsigned T1H_CYC_DEF  = 8;     // 800 ns
    localparam int unsigned TBIT_CYC_DEF = 13;    // 1.3 us
    localparam int unsigned TRST_CYC_DEF = 3000;  // 300 us

    // Round a duration in ns up to whole clock cycles at clk_hz.
    function automatic int unsigned ns_to_cyc(input int unsigned ns, input int unsigned clk_hz);
        longint unsigned prod;
        prod = longint'(ns) * longint'(clk_hz) + 64'd999_999_999;
        return int'(prod / 64'd1_000_000_000);
    endfunction

endpackage

// File: rtl/rgbled_bit_tx.sv
// One-bit NRZ encoder: on start drives the line high for T0H/T1H cycles
// (per bit value), then low for the remainder of TBIT cycles. done is
// combinational in the final cycle so a back-to-back start keeps bits
// exactly TBIT cycles apart.
module rgbled_bit_tx #(
    parameter int unsigned T0H_CYC  = 4,
    parameter int unsigned T1H_CYC  = 8,
    parameter int unsigned TBIT_CYC = 13
) (
    input  logic clk,
    input  logic nreset,
    input  logic start,
    input  logic bit_val,
    output logic led,
    output logic hi_last,
    output logic done
);
    localparam int unsigned CW = (TBIT_CYC > 1) ? $clog2(TBIT_CYC) : 1;
    localparam logic [CW-1:0] T0H_L  = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H_L  = CW'(T1H_CYC);
    localparam logic [CW-1:0] TEND_L = CW'(TBIT_CYC - 1);

    logic          active;
    logic [CW-1:0] cnt;
    logic [CW-1:0] high;

    assign hi_last = active && (cnt == high - CW'(1));
    assign done    = active && (cnt == TEND_L);

    // Cycle counter and registered line level for the bit in flight.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            active <= 1'b0;
            led    <= 1'b0;
            cnt    <= '0;
            high   <= '0;
        end else if (start) begin
            active <= 1'b1;
            led    <= 1'b1;
            cnt    <= '0;
            high   <= bit_val ? T1H_L : T0H_L;
        end else if (active) begin
            if (hi_last) led <= 1'b0;
            if (done) active <= 1'b0;
            else      cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rgbled_stream.sv
// WS2812-class LED chain driver. Serialises LED_COUNT*BITS_PER_LED bits,
// LED0 first and MSB first within each LED, then holds the line low for
// the latch time. A strobe while busy is parked in a pending buffer
// (latest wins) and started straight after the latch phase.
// Optional feature macro: RGBLED_BRIGHTNESS_EN adds an 8-bit brightness
// input that scales every 8-bit field as the frame is loaded.
module rgbled_stream
    import rgbled_pkg::*;
#(
    parameter int unsigned LED_COUNT    = 3,
    parameter int unsigned BITS_PER_LED = 24,
    parameter int unsigned T0H_CYC      = T0H_CYC_DEF,
    parameter int unsigned T1H_CYC      = T1H_CYC_DEF,
    parameter int unsigned TBIT_CYC     = TBIT_CYC_DEF,
    parameter int unsigned TRST_CYC     = TRST_CYC_DEF
) (
    input  logic                              clk,
    input  logic                              nreset,
    input  logic [LED_COUNT*BITS_PER_LED-1:0] data,
    input  logic                              data_rdy,
`ifdef RGBLED_BRIGHTNESS_EN
    input  logic [7:0]                        brightness,
`endif
    output logic                              led,
    output logic                              busy,
    output logic                              frame_done
);
    localparam int unsigned FW  = LED_COUNT * BITS_PER_LED;
    localparam int unsigned LIW = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
    localparam int unsigned BIW = $clog2(BITS_PER_LED);
    localparam int unsigned RCW = $clog2(TRST_CYC + 1);

    rgbled_state_t  state;
    logic [FW-2:0]  sr;        // bits still to send after the one in flight
    logic [FW-1:0]  pend_buf;
    logic           pend;
    logic [LIW-1:0] led_idx;
    logic [BIW-1:0] bit_idx;
    logic [RCW-1:0] lcnt;

    logic [FW-1:0]  load_src;
    logic [FW-1:0]  scaled;
    logic [FW-1:0]  ordered;
    logic           last_bit;
    logic           latch_end;
    logic           start_frame;
    logic           tx_start;
    logic           tx_bit;
    logic           tx_hi_last;
    logic           tx_done;

    // A fresh strobe always beats the parked frame.
    assign load_src = data_rdy ? data : pend_buf;

`ifdef RGBLED_BRIGHTNESS_EN
    for (genvar f = 0; f < FW / 8; f++) begin : g_scale
        assign scaled[f*8 +: 8] =
            8'(({8'd0, load_src[f*8 +: 8]} * ({8'd0, brightness} + 16'd1)) >> 8);
    end
`else
    assign scaled = load_src;
`endif

    // Put LED0 at the top so the frame streams out of the MSB end.
    for (genvar i = 0; i < LED_COUNT; i++) begin : g_order
        assign ordered[(LED_COUNT-1-i)*BITS_PER_LED +: BITS_PER_LED] =
            scaled[i*BITS_PER_LED +: BITS_PER_LED];
    end

    assign last_bit    = (led_idx == LIW'(LED_COUNT - 1)) && (bit_idx == '0);
    assign latch_end   = (state == LATCH) && (lcnt == RCW'(TRST_CYC));
    assign start_frame = ((state == IDLE) && data_rdy) || (latch_end && (data_rdy || pend));
    assign tx_start    = start_frame || ((state == BIT_LO) && tx_done && !last_bit);
    assign tx_bit      = start_frame ? ordered[FW-1] : sr[FW-2];

    rgbled_bit_tx #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC)
    ) u_bit_tx (
        .clk     (clk),
        .nreset  (nreset),
        .start   (tx_start),
        .bit_val (tx_bit),
        .led     (led),
        .hi_last (tx_hi_last),
        .done    (tx_done)
    );

    // Frame sequencing: bit/LED indices, latch timer, pending buffer, status.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            sr         <= '0;
            pend_buf   <= '0;
            pend       <= 1'b0;
            led_idx    <= '0;
            bit_idx    <= '0;
            lcnt       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (data_rdy && (state != IDLE) && !latch_end) begin
                pend_buf <= data;
                pend     <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (data_rdy) begin
                        sr      <= ordered[FW-2:0];
                        led_idx <= '0;
                        bit_idx <= BIW'(BITS_PER_LED - 1);
                        busy    <= 1'b1;
                        state   <= BIT_HI;
                    end
                end
                BIT_HI: begin
                    if (tx_hi_last) state <= BIT_LO;
                end
                BIT_LO: begin
                    if (tx_done) begin
                        if (last_bit) begin
                            lcnt  <= '0;
                            state <= LATCH;
                        end else begin
                            sr    <= {sr[FW-3:0], 1'b0};
                            state <= BIT_HI;
                            if (bit_idx == '0) begin
                                bit_idx <= BIW'(BITS_PER_LED - 1);
                                led_idx <= led_idx + LIW'(1);
                            end else begin
                                bit_idx <= bit_idx - BIW'(1);
                            end
                        end
                    end
                end
                LATCH: begin
                    if (latch_end) begin
                        pend <= 1'b0;
                        if (data_rdy || pend) begin
                            sr      <= ordered[FW-2:0];
                            led_idx <= '0;
                            bit_idx <= BIW'(BITS_PER_LED - 1);
                            state   <= BIT_HI;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        // frame_done lands in the final latch cycle
                        if (lcnt == RCW'(TRST_CYC - 1)) frame_done <= 1'b1;
                        lcnt <= lcnt + RCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgbled_stream.sv
// Self-checking bench for rgbled_stream: a frame-level timing model predicts
// led/busy/frame_done every cycle; directed frames are also decoded from
// the pulse widths on led and compared with the expected bitstream.
module tb_rgbled_stream;
    localparam int LC = 3, BPL = 24, FW = LC * BPL;
    localparam int T0H = 4, T1H = 8, TBIT = 13, TRST = 3000;
    localparam int FRAME = FW * TBIT + TRST + 1;   // busy cycles per frame

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          data_rdy = 1'b0;
    logic [FW-1:0] data = '0;
    logic [7:0]    brightness = 8'hFF;
    logic          led, busy, frame_done;

    int checks = 0, errors = 0;

    // reference model state
    int            t_left = 0;
    logic          pend_v = 1'b0;
    logic [FW-1:0] pend_d = '0;
    logic [FW-1:0] cur = '0;

    // waveform measurement
    int            cyc = 0;
    logic          meas_on = 1'b0;
    logic          led_prev = 1'b0;
    int            hi_len, n_hi, bad_w, rise_cyc, fd_cyc;
    logic [FW-1:0] dec;

    rgbled_stream #(
        .LED_COUNT(LC), .BITS_PER_LED(BPL), .T0H_CYC(T0H),
        .T1H_CYC(T1H), .TBIT_CYC(TBIT), .TRST_CYC(TRST)
    ) dut (
        .clk(clk), .nreset(nreset), .data(data), .data_rdy(data_rdy),
`ifdef RGBLED_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .led(led), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [FW-1:0] scale(input logic [FW-1:0] d, input int b);
        logic [FW-1:0] r;
        for (int f = 0; f < FW / 8; f++) r[f*8 +: 8] = 8'((int'(d[f*8 +: 8]) * (b + 1)) / 256);
        return r;
    endfunction

    // k-th transmitted bit: LED k/BPL, MSB first inside the LED
    function automatic logic bit_of(input logic [FW-1:0] d, input int k);
        return d[(k / BPL) * BPL + (BPL - 1 - k % BPL)];
    endfunction

    task automatic m_start(input logic [FW-1:0] d);
        cur    = scale(d, int'(brightness));
        t_left = FRAME;
    endtask

    task automatic model_step();
        if (!nreset) begin
            t_left = 0;
            pend_v = 1'b0;
        end else if (t_left == 0) begin
            if (data_rdy) m_start(data);
        end else if (t_left == 1) begin
            if (data_rdy)    m_start(data);
            else if (pend_v) m_start(pend_d);
            else             t_left = 0;
            pend_v = 1'b0;
        end else begin
            if (data_rdy) begin
                pend_v = 1'b1;
                pend_d = data;
            end
            t_left--;
        end
    endtask

    function automatic logic [2:0] exp_out();
        int   p;
        logic l;
        l = 1'b0;
        if (t_left > 0) begin
            p = FRAME - t_left;
            if (p < FW * TBIT) l = (p % TBIT) < (bit_of(cur, p / TBIT) ? T1H : T0H);
        end
        return {l, t_left != 0, t_left == 1};
    endfunction

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        chk(tag, {led, busy, frame_done}, exp_out());
        if (meas_on) begin
            if (led) hi_len++;
            else if (led_prev) begin
                dec = {dec[FW-2:0], hi_len == T1H};
                n_hi++;
                if (hi_len != T0H && hi_len != T1H) bad_w++;
                hi_len = 0;
            end
            if (led && !led_prev && rise_cyc < 0) rise_cyc = cyc;
            if (frame_done && fd_cyc < 0) fd_cyc = cyc;
        end
        led_prev = led;
    endtask

    task automatic run_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic strobe(input logic [FW-1:0] d, input string tag);
        data     = d;
        data_rdy = 1'b1;
        cycle(tag);
        data_rdy = 1'b0;
    endtask

    task automatic run_until_p(input int target, input string tag);
        int n;
        n = 0;
        while (!(t_left > 0 && FRAME - t_left == target) && n < 2 * FRAME) begin
            cycle(tag);
            n++;
        end
        chk({tag, "_timeout"}, n >= 2 * FRAME, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (t_left != 0 && n < 3 * FRAME) begin
            cycle(tag);
            n++;
        end
        chk({tag, "_timeout"}, n >= 3 * FRAME, 1'b0);
    endtask

    // send one frame and decode it from led pulse widths
    task automatic measure_frame(input logic [FW-1:0] d, input logic [FW-1:0] sent, input string tag);
        logic [FW-1:0] ev;
        for (int k = 0; k < FW; k++) ev[FW-1-k] = bit_of(sent, k);
        hi_len = 0; n_hi = 0; bad_w = 0; rise_cyc = -1; fd_cyc = -1; dec = '0;
        meas_on = 1'b1;
        strobe(d, tag);
        wait_idle(tag);
        run_idle(5, tag);
        meas_on = 1'b0;
        chk({tag, "_nbits"}, n_hi, FW);
        chk({tag, "_widths"}, bad_w, 0);
        chk({tag, "_bits"}, dec, ev);
        chk({tag, "_len"}, fd_cyc - rise_cyc, FW * TBIT + TRST);
    endtask

    initial begin
        logic [FW-1:0] a, b, c, rd;

        // reset held, then idle
        run_idle(5, "reset");
        chk("reset_led", led, 1'b0);
        chk("reset_busy", busy, 1'b0);
        nreset = 1'b1;
        run_idle(100, "idle");

        // directed frame with pulse-width decode
        measure_frame(72'h00FF00_800001_AAAAAA, 72'h00FF00_800001_AAAAAA, "frame0");

        // A, then B at bit 10, C at bit 40: C follows A, B dropped
        a = 72'h123456_789ABC_DEF012;
        b = 72'hFFFFFF_FFFFFF_FFFFFF;
        c = 72'h80C3A5_5A3C01_F00F96;
        strobe(a, "abc");
        run_until_p(10 * TBIT, "abc");
        strobe(b, "abc");
        run_until_p(40 * TBIT, "abc");
        strobe(c, "abc");
        run_until_p(FW * TBIT + TRST, "abc");
        chk("abc_done", frame_done, 1'b1);
        cycle("abc");
        chk("abc_c_rise", led, 1'b1);
        chk("abc_c_busy", busy, 1'b1);
        wait_idle("abc");

        // reset while bit 30 is high with a frame pending
        strobe(a, "rst");
        run_until_p(20 * TBIT, "rst");
        strobe(b, "rst");
        run_until_p(30 * TBIT + 2, "rst");
        #2 nreset = 1'b0;
        #1;
        chk("rst_led_async", led, 1'b0);
        chk("rst_busy_async", busy, 1'b0);
        t_left = 0;
        pend_v = 1'b0;
        run_idle(3, "rst_hold");
        nreset = 1'b1;
        run_idle(200, "rst_after");

        // strobe in the frame_done cycle starts at once
        strobe(c, "latch");
        run_until_p(FW * TBIT + TRST, "latch");
        strobe(a, "latch");
        chk("latch_rise", led, 1'b1);
        chk("latch_busy", busy, 1'b1);
        wait_idle("latch");
        run_idle(10, "latch");

`ifdef RGBLED_BRIGHTNESS_EN
        brightness = 8'd127;
        measure_frame({FW{1'b1}}, {(FW/8){8'h7F}}, "bri127");
        brightness = 8'd0;
        measure_frame(72'hFFA512_FF0080_FFFFFF, '0, "bri0");
        brightness = 8'd255;
        measure_frame(72'h00FF00_800001_AAAAAA, 72'h00FF00_800001_AAAAAA, "bri255");
`endif

        // randomized strobes, sometimes while busy
        for (int r = 0; r < 5; r++) begin
`ifdef RGBLED_BRIGHTNESS_EN
            brightness = 8'($urandom_range(0, 255));
`endif
            rd = FW'({$urandom(), $urandom(), $urandom()});
            run_idle($urandom_range(0, 20), "rand");
            strobe(rd, "rand");
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                run_idle($urandom_range(1, 1500), "rand");
`ifdef RGBLED_BRIGHTNESS_EN
                brightness = 8'($urandom_range(0, 255));
`endif
                rd = FW'({$urandom(), $urandom(), $urandom()});
                strobe(rd, "rand");
            end
            wait_idle("rand");
        end
        run_idle(20, "tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
